// File: rtl/debugger_tx.sv
// debugger_tx: streams NUM_WORDS 32-bit debug words to the UART TX FIFO, MSB byte first.
// Optional trailing XOR checksum byte when DEBUGGER_TX_CHECKSUM_EN is defined.
`default_nettype none

module debugger_tx #(
  parameter int NUM_WORDS = 34,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              send_data,
  input  logic [31:0]       dbg_word,
  input  logic              tx_full,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        w_data,
  output logic              wr_uart,
  output logic              data_sent,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef DEBUGGER_TX_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd4;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shreg_q,    shreg_d;
  logic              send_q;
  logic              start;
`ifdef DEBUGGER_TX_CHECKSUM_EN
  logic [7:0]        chk_q,      chk_d;
`endif

  // Rising edge of the request level: a held level starts only one dump.
  assign start = send_data & ~send_q;

  // word_idx only changes on entry to FETCH, so it doubles as the held address.
  assign dbg_addr = word_idx_q;

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      send_q     <= 1'b0;
`ifdef DEBUGGER_TX_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      send_q     <= send_data;
`ifdef DEBUGGER_TX_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
`ifdef DEBUGGER_TX_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          word_idx_d = '0;
`ifdef DEBUGGER_TX_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      S_FETCH: begin
        shreg_d    = dbg_word;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (!tx_full) begin
          shreg_d    = {shreg_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef DEBUGGER_TX_CHECKSUM_EN
          chk_d      = chk_q ^ shreg_q[31:24];
`endif
          if (byte_cnt_q == 2'd3) begin
            if (word_idx_q == LAST_IDX) begin
`ifdef DEBUGGER_TX_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end else begin
              word_idx_d = word_idx_q + 1'b1;
              state_d    = S_FETCH;
            end
          end
        end
      end
`ifdef DEBUGGER_TX_CHECKSUM_EN
      S_CHK: begin
        if (!tx_full) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_uart   = 1'b0;
    w_data    = 8'h00;
    data_sent = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_SEND: begin
        wr_uart = ~tx_full;
        w_data  = shreg_q[31:24];
      end
`ifdef DEBUGGER_TX_CHECKSUM_EN
      S_CHK: begin
        wr_uart = ~tx_full;
        w_data  = chk_q;
      end
`endif
      S_DONE:  data_sent = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_debugger_tx.sv
// Self-checking bench for debugger_tx with NUM_WORDS=2 and per-cycle expected vectors.
`default_nettype none

module tb_debugger_tx;

  localparam int NW = 2;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          global_reset;
  logic          send_data;
  logic          tx_full;
  logic [31:0]   dbg_word;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    w_data;
  logic          wr_uart;
  logic          data_sent;
  logic          busy;

  always #5 clk = ~clk;

  assign dbg_word = (dbg_addr == '0) ? 32'h1122_3344 : 32'hAABB_CCDD;

  debugger_tx #(.NUM_WORDS(NW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .global_reset(global_reset),
    .send_data   (send_data),
    .dbg_word    (dbg_word),
    .tx_full     (tx_full),
    .dbg_addr    (dbg_addr),
    .w_data      (w_data),
    .wr_uart     (wr_uart),
    .data_sent   (data_sent),
    .busy        (busy)
  );

  typedef struct {
    logic          s;
    logic          f;
    logic          wr;
    logic [7:0]    wd;
    logic          ds;
    logic          bz;
    logic [AW-1:0] ad;
  } vec_t;

  vec_t          vq[$];
  int            n_vec = 0;
  int            n_bad = 0;
  logic [AW-1:0] last_addr;
  logic [7:0]    bytes_c[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic push(input logic s, input logic f, input logic wr, input logic [7:0] wd,
                      input logic ds, input logic bz, input logic [AW-1:0] ad);
    vec_t v;
    v.s = s; v.f = f; v.wr = wr; v.wd = wd; v.ds = ds; v.bz = bz; v.ad = ad;
    vq.push_back(v);
  endtask

  task automatic idle(input logic s, input int n);
    for (int i = 0; i < n; i++) push(s, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, last_addr);
  endtask

  // Expected per-cycle outputs of one full dump, starting with the IDLE cycle that sees the request.
  task automatic add_dump(input logic hold, input int stall_byte, input int stall_n, input int pulse_at);
    int   cyc;
    logic s;
    cyc = 0;
    push(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, last_addr);
    for (int w = 0; w < NW; w++) begin
      s = hold | (cyc == pulse_at); cyc++;
      push(s, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, AW'(w));
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b == stall_byte) begin
          for (int i = 0; i < stall_n; i++) begin
            s = hold | (cyc == pulse_at); cyc++;
            push(s, 1'b1, 1'b0, bytes_c[w*4+b], 1'b0, 1'b1, AW'(w));
          end
        end
        s = hold | (cyc == pulse_at); cyc++;
        push(s, 1'b0, 1'b1, bytes_c[w*4+b], 1'b0, 1'b1, AW'(w));
      end
    end
`ifdef DEBUGGER_TX_CHECKSUM_EN
    s = hold | (cyc == pulse_at); cyc++;
    push(s, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, AW'(NW - 1));
`endif
    s = hold | (cyc == pulse_at);
    push(s, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, AW'(NW - 1));
    last_addr = AW'(NW - 1);
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, wr_uart, w_data, data_sent, busy, dbg_addr};
  endfunction

  function automatic logic [31:0] pack(input vec_t v);
    return {15'd0, v.wr, v.wd, v.ds, v.bz, v.ad};
  endfunction

  initial begin
    int nw;
    int t;
    bytes_c = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    last_addr    = '0;
    global_reset = 1'b1;
    send_data    = 1'b0;
    tx_full      = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset_state", outs(), 32'h0);
    @(negedge clk) global_reset = 1'b0;

    idle(1'b0, 2);
    add_dump(1'b0, -1, 0, -1); idle(1'b0, 2);   // plain dump
    add_dump(1'b0, 2, 3, -1);  idle(1'b0, 2);   // backpressure on 0x33
    add_dump(1'b1, -1, 0, -1); idle(1'b1, 8);   // level held across completion
    idle(1'b0, 2);
    add_dump(1'b0, -1, 0, -1); idle(1'b0, 2);   // re-armed after low
    add_dump(1'b0, -1, 0, 3);  idle(1'b0, 2);   // stray request while busy

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      send_data = vq[i].s;
      tx_full   = vq[i].f;
      #1 chk($sformatf("vec%0d", i), outs(), pack(vq[i]));
    end

    // Asynchronous reset in the middle of a dump, then a clean restart.
    @(negedge clk) send_data = 1'b1;
    @(negedge clk) send_data = 1'b0;
    nw = 0;
    t  = 0;
    while (1) begin
      #1;
      if (wr_uart) nw++;
      if (nw >= 5 || t >= 40) break;
      t++;
      @(negedge clk);
    end
    chk("bytes_before_reset", 32'(nw), 32'd5);
    @(posedge clk);
    #2 global_reset = 1'b1;
    #1 chk("async_reset_outputs", outs(), 32'h0);
    @(negedge clk) global_reset = 1'b0;
    #1 chk("idle_after_reset", outs(), 32'h0);
    @(negedge clk) send_data = 1'b1;
    @(negedge clk) send_data = 1'b0;
    t = 0;
    while (1) begin
      #1;
      if (wr_uart || t >= 20) break;
      t++;
      @(negedge clk);
    end
    chk("restart_first_byte", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, 8'h11});
    chk("restart_addr", 32'(dbg_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
